grant_decoder_seq: RTL

- Sequential counterpart of the team's priority encoders: accepts a stream of encoded indices and drives registered one-hot grant lines.
- Indices are buffered in a small FIFO. Each grant is held until the target acknowledges it.
- Every grant is followed by one all-zero cycle (break-before-make).
- Sits between the priority-encoder request path and the one-hot resource-select lines.

---
 rtl/grant_decoder_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/grant_decoder_seq.sv
// Buffers encoded indices in a small FIFO and drives registered one-hot grants with a break-before-make gap.
// Optional per-line saturating grant counters are enabled with `define GRANT_COUNT_EN.
module grant_decoder_seq #(
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_MIN   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IDX_W-1:0]                in_idx,
  output logic                            out_valid,
  output logic [(1<<IDX_W)-1:0]           out_onehot,
  input  logic                            out_ack,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            busy
`ifdef GRANT_COUNT_EN
  ,
  output logic [(1<<IDX_W)*8-1:0]         grant_cnt
`endif
);

  localparam int OUT_W  = 1 << IDX_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int HCNT_W = $clog2(HOLD_MIN + 1);
  localparam logic [HCNT_W-1:0] HOLD_SAT  = HCNT_W'(HOLD_MIN);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_MIN - 1);
  localparam logic [OUT_W-1:0]  ONE_HOT0  = OUT_W'(1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W:0]      rdPtr_q, rdPtr_d;
  logic [HCNT_W-1:0]   holdCnt_q;
  logic                valid_q;
  logic [OUT_W-1:0]    onehot_q;

  logic                fifoEmpty, fifoFull;
  logic                push, pop, ackTaken, holdDone;
  logic [IDX_W-1:0]    headIdx;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign push      = in_valid & ~fifoFull;
  assign pop       = (state_q != GRANT) & ~fifoEmpty;
  assign headIdx   = mem_q[rdPtr_q[PTR_W-1:0]];
  assign holdDone  = (holdCnt_q == HOLD_LAST) || (holdCnt_q == HOLD_SAT);
  assign ackTaken  = (state_q == GRANT) & valid_q & out_ack & holdDone;

  assign wrPtr_d   = push ? wrPtr_q + 1'b1 : wrPtr_q;
  assign rdPtr_d   = pop  ? rdPtr_q + 1'b1 : rdPtr_q;

  assign in_ready   = ~fifoFull;
  assign fifo_count = wrPtr_q - rdPtr_q;
  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign busy       = valid_q | (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[PTR_W-1:0]] <= in_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // IDLE and GAP both pop straight into GRANT, so GAP never lasts more than one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      holdCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (pop) begin
            valid_q   <= 1'b1;
            onehot_q  <= ONE_HOT0 << headIdx;
            holdCnt_q <= '0;
            state_q   <= GRANT;
          end else begin
            state_q   <= IDLE;
          end
        end
        GRANT: begin
          if (holdCnt_q != HOLD_SAT) holdCnt_q <= holdCnt_q + 1'b1;
          if (ackTaken) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
            state_q  <= GAP;
          end
        end
        default: begin
          valid_q  <= 1'b0;
          onehot_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

`ifdef GRANT_COUNT_EN
  logic [7:0] grantCnt_q [OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OUT_W; k++) grantCnt_q[k] <= 8'd0;
    end else begin
      for (int k = 0; k < OUT_W; k++) begin
        if (ackTaken && onehot_q[k] && (grantCnt_q[k] != 8'hFF))
          grantCnt_q[k] <= grantCnt_q[k] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < OUT_W; g++) begin : g_cnt
    assign grant_cnt[8*g +: 8] = grantCnt_q[g];
  end
`endif

endmodule
